// File: rtl/cram_pkg.sv
// Shared constants and state encoding for the CellularRAM device-side responder.
package cram_pkg;
   localparam int ADDR_W       = 26;
   localparam int DATA_W       = 16;
   localparam int READ_LAT_DEF = 7;
   localparam int LAT_W        = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_WAIT   = 3'd1,
      ST_RD_DRIVE  = 3'd2,
      ST_WR_ACTIVE = 3'd3,
      ST_IGNORE    = 3'd4
   } state_e;
endpackage

// File: rtl/cram_bram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module cram_bram
   import cram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
)(
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [1:0]            be_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);
   // Contents come up zero at configuration; reset never touches them.
   logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1] = '{default: '0};
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      if (we_i && be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/cram_responder.sv
// Device-side CellularRAM emulation: registered pin sampling, read latency,
// byte-lane drive enables and write commit on the strobe's rising edge.
module cram_responder
   import cram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int READ_LAT   = READ_LAT_DEF,
   parameter bit WAIT_EN    = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_n,
   input  logic              oe_n,
   input  logic              we_n,
   input  logic              adv_n,
   input  logic              ub_n,
   input  logic              lb_n,
   input  logic              cre,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] db_i,
   output logic [DATA_W-1:0] db_o,
   output logic [1:0]        db_oe,
   output logic              wait_o,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

   logic                  ce_n_q, oe_n_q, we_n_q, adv_n_q, ub_n_q, lb_n_q, cre_q;
   logic [DEPTH_LOG2-1:0] addr_q;
   logic [DATA_W-1:0]     db_i_q;
   logic                  addr_unused;

   // Upper address bits alias onto the stored range.
   assign addr_unused = ^addr[ADDR_W-1:DEPTH_LOG2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         adv_n_q <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         cre_q   <= 1'b0;
         addr_q  <= '0;
         db_i_q  <= '0;
      end else begin
         ce_n_q  <= ce_n;
         oe_n_q  <= oe_n;
         we_n_q  <= we_n;
         adv_n_q <= adv_n;
         ub_n_q  <= ub_n;
         lb_n_q  <= lb_n;
         cre_q   <= cre;
         addr_q  <= addr[DEPTH_LOG2-1:0];
         db_i_q  <= db_i;
      end
   end

   state_e                state_q, state_d;
   logic [LAT_W-1:0]      cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] la_q, la_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d, db_o_q, db_o_d;
   logic [1:0]            wbe_q, wbe_d, db_oe_q, db_oe_d;
   logic [15:0]           rd_count_q, rd_count_d, wr_count_q, wr_count_d;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_rdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      la_d       = la_q;
      wdata_d    = wdata_q;
      wbe_d      = wbe_q;
      db_o_d     = db_o_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      mem_we     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!ce_n_q) begin
               if (cre_q) begin
                  state_d = ST_IGNORE;
               end else if (!we_n_q) begin
                  state_d = ST_WR_ACTIVE;
                  if (!adv_n_q) la_d = addr_q;
               end else if (!oe_n_q && !adv_n_q) begin
                  state_d = ST_RD_WAIT;
                  la_d    = addr_q;
                  cnt_d   = LAT_LOAD;
               end
            end
         end
         ST_RD_WAIT: begin
            if (ce_n_q) begin
               state_d = ST_IDLE;
            end else if (!we_n_q) begin
               state_d = ST_WR_ACTIVE;
               if (!adv_n_q) la_d = addr_q;
            end else if (oe_n_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_RD_DRIVE;
               db_o_d  = mem_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RD_DRIVE: begin
            if (ce_n_q) begin
               state_d    = ST_IDLE;
               rd_count_d = rd_count_q + 16'd1;
            end else if (!we_n_q) begin
               state_d = ST_WR_ACTIVE;
               if (!adv_n_q) la_d = addr_q;
            end else if (oe_n_q) begin
               state_d    = ST_IDLE;
               rd_count_d = rd_count_q + 16'd1;
            end else if (!adv_n_q && (addr_q != la_q)) begin
               state_d = ST_RD_WAIT;
               la_d    = addr_q;
               cnt_d   = LAT_LOAD;
            end
         end
         ST_WR_ACTIVE: begin
            if (ce_n_q || we_n_q) begin
               mem_we     = 1'b1;
               wr_count_d = wr_count_q + 16'd1;
               state_d    = ST_IDLE;
            end else if (!adv_n_q) begin
               la_d = addr_q;
            end
         end
         ST_IGNORE: begin
            if (ce_n_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Commit uses data and lanes from the last cycle the strobe was still low.
      if (state_d == ST_WR_ACTIVE && !we_n_q) begin
         wdata_d = db_i_q;
         wbe_d   = {~ub_n_q, ~lb_n_q};
      end
      db_oe_d = (state_d == ST_RD_DRIVE) ? {~ub_n_q, ~lb_n_q} : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         la_q       <= '0;
         wdata_q    <= '0;
         wbe_q      <= 2'b00;
         db_o_q     <= '0;
         db_oe_q    <= 2'b00;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         la_q       <= la_d;
         wdata_q    <= wdata_d;
         wbe_q      <= wbe_d;
         db_o_q     <= db_o_d;
         db_oe_q    <= db_oe_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Addressed with next-state latch so a 1-cycle latency still sees the new word.
   cram_bram #(.DEPTH_LOG2(DEPTH_LOG2)) u_bram (
      .clk     (clk),
      .we_i    (mem_we),
      .be_i    (wbe_q),
      .addr_i  (la_d),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   assign db_o     = db_o_q;
   assign db_oe    = db_oe_q;
   assign wait_o   = WAIT_EN && (state_q == ST_RD_WAIT);
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
endmodule

// File: tb/tb_cram_responder.sv
// Directed plus randomized bench for cram_responder against a word-array model.
module tb_cram_responder;
   localparam int L = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, adv_n = 1'b1;
   logic        ub_n = 1'b1, lb_n = 1'b1, cre = 1'b0;
   logic [25:0] addr = '0;
   logic [15:0] db_i = '0;
   logic [15:0] db_o;
   logic [1:0]  db_oe;
   logic        wait_o;
   logic [15:0] rd_count, wr_count;

   always #5 clk = ~clk;

   cram_responder #(.DEPTH_LOG2(10), .READ_LAT(L), .WAIT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .adv_n(adv_n),
      .ub_n(ub_n), .lb_n(lb_n), .cre(cre), .addr(addr), .db_i(db_i),
      .db_o(db_o), .db_oe(db_oe), .wait_o(wait_o), .rd_count(rd_count), .wr_count(wr_count)
   );

   logic [15:0] mdl [0:1023];
   int errors = 0, checks = 0;
   int exp_rd = 0, exp_wr = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [25:0] a, input logic [15:0] d,
                           input logic ub, input logic lb, input logic o);
      int bad = 0;
      ce_n = 1'b0; we_n = 1'b0; oe_n = o; adv_n = 1'b0; addr = a; db_i = d; ub_n = ub; lb_n = lb;
      tick(); if (db_oe !== 2'b00) bad++;
      adv_n = 1'b1;
      tick(); if (db_oe !== 2'b00) bad++;
      we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; db_i = ~d;
      tick(); if (db_oe !== 2'b00) bad++;
      tick(); if (db_oe !== 2'b00) bad++;
      if (!ub) mdl[a[9:0]][15:8] = d[15:8];
      if (!lb) mdl[a[9:0]][7:0]  = d[7:0];
      exp_wr++;
      check("wr_no_drive", bad, 0);
      check("wr_count", wr_count, 16'(exp_wr));
   endtask

   task automatic start_read(input logic [25:0] a, input logic ub, input logic lb);
      ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; adv_n = 1'b0; addr = a; ub_n = ub; lb_n = lb;
      tick();
      adv_n = 1'b1;
      tick();
   endtask

   task automatic wait_data(input logic [15:0] exp_d, input logic [1:0] exp_oe);
      int waits = 0, early = 0;
      for (int k = 0; k < L; k++) begin
         if (wait_o === 1'b1) waits++;
         if (db_oe !== 2'b00) early++;
         tick();
      end
      check("rd_wait_cycles", waits, L);
      check("rd_early_drive", early, 0);
      check("rd_data", db_o, exp_d);
      check("rd_oe", db_oe, exp_oe);
      check("rd_wait_clear", wait_o, 1'b0);
   endtask

   task automatic end_read();
      ce_n = 1'b1; oe_n = 1'b1;
      tick();
      tick();
      exp_rd++;
      check("rd_release", db_oe, 2'b00);
      check("rd_count", rd_count, 16'(exp_rd));
   endtask

   task automatic do_read(input logic [25:0] a, input logic ub, input logic lb);
      start_read(a, ub, lb);
      wait_data(mdl[a[9:0]], {~ub, ~lb});
      end_read();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mdl[i] = 16'h0000;

      // reset state
      tick(); tick();
      check("rst_db_o", db_o, 16'h0);
      check("rst_db_oe", db_oe, 2'b00);
      check("rst_wait", wait_o, 1'b0);
      check("rst_rd_count", rd_count, 16'h0);
      check("rst_wr_count", wr_count, 16'h0);
      rst = 1'b0;
      tick();

      // write then read
      do_write(26'h5, 16'hBEEF, 1'b0, 1'b0, 1'b1);
      do_read(26'h5, 1'b0, 1'b0);

      // byte lanes
      do_write(26'h10, 16'hAAAA, 1'b0, 1'b0, 1'b1);
      do_write(26'h10, 16'h1234, 1'b0, 1'b1, 1'b1);
      check("lane_model", mdl[10'h10], 16'h12AA);
      do_read(26'h10, 1'b0, 1'b0);
      do_read(26'h10, 1'b1, 1'b0);

      // aborted read
      begin
         int bad = 0;
         start_read(26'h5, 1'b0, 1'b0);
         for (int k = 0; k < 3; k++) begin if (db_oe !== 2'b00) bad++; tick(); end
         oe_n = 1'b1; ce_n = 1'b1;
         tick(); if (db_oe !== 2'b00) bad++;
         tick(); if (db_oe !== 2'b00) bad++;
         check("abort_no_drive", bad, 0);
         check("abort_wait", wait_o, 1'b0);
         check("abort_rd_count", rd_count, 16'(exp_rd));
      end
      do_read(26'h5, 1'b0, 1'b0);

      // write priority over output enable
      do_write(26'h3, 16'h5A5A, 1'b0, 1'b0, 1'b0);
      do_read(26'h3, 1'b0, 1'b0);

      // control-register access is ignored
      do_write(26'h0, 16'h1111, 1'b0, 1'b0, 1'b1);
      ce_n = 1'b0; cre = 1'b1; we_n = 1'b0; adv_n = 1'b0; addr = 26'h0; db_i = 16'hFFFF;
      ub_n = 1'b0; lb_n = 1'b0;
      tick(); adv_n = 1'b1;
      tick(); we_n = 1'b1; ce_n = 1'b1;
      tick(); tick(); cre = 1'b0;
      tick();
      check("cre_wr_count", wr_count, 16'(exp_wr));
      check("cre_rd_count", rd_count, 16'(exp_rd));
      check("cre_no_drive", db_oe, 2'b00);
      do_read(26'h0, 1'b0, 1'b0);

      // address aliasing
      do_write(26'h400, 16'h0777, 1'b0, 1'b0, 1'b1);
      do_read(26'h0, 1'b0, 1'b0);

      // lane tracking, re-address and write interrupt while driving
      start_read(26'h5, 1'b0, 1'b0);
      wait_data(mdl[10'h5], 2'b11);
      ub_n = 1'b1;
      tick(); tick();
      check("drive_lane_track", db_oe, 2'b01);
      adv_n = 1'b0; addr = 26'h10;
      tick(); adv_n = 1'b1;
      tick();
      check("readdr_drop", db_oe, 2'b00);
      wait_data(mdl[10'h10], 2'b01);
      we_n = 1'b0; db_i = 16'h4321; ub_n = 1'b0; lb_n = 1'b0;
      tick(); tick();
      check("rd2wr_drop", db_oe, 2'b00);
      we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1;
      tick(); tick();
      mdl[10'h10] = 16'h4321;
      exp_wr++;
      check("rd2wr_wr_count", wr_count, 16'(exp_wr));
      check("rd2wr_rd_count", rd_count, 16'(exp_rd));
      do_read(26'h10, 1'b0, 1'b0);

      // asynchronous reset while driving
      start_read(26'h10, 1'b0, 1'b0);
      wait_data(mdl[10'h10], 2'b11);
      #2 rst = 1'b1;
      #1;
      check("rst_async_oe", db_oe, 2'b00);
      check("rst_async_rd_count", rd_count, 16'h0);
      ce_n = 1'b1; oe_n = 1'b1;
      exp_rd = 0; exp_wr = 0;
      tick(); rst = 1'b0;
      tick();

      // reset in the middle of a write
      do_write(26'h20, 16'h0F0F, 1'b0, 1'b0, 1'b1);
      ce_n = 1'b0; we_n = 1'b0; adv_n = 1'b0; addr = 26'h20; db_i = 16'h1111;
      tick(); adv_n = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      check("rstwr_wr_count", wr_count, 16'h0);
      check("rstwr_oe", db_oe, 2'b00);
      ce_n = 1'b1; we_n = 1'b1;
      exp_wr = 0;
      tick(); rst = 1'b0;
      tick(); tick();
      do_read(26'h20, 1'b0, 1'b0);

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         logic [25:0] ra;
         logic [15:0] rd;
         logic        rub, rlb;
         ra  = 26'($urandom_range(0, 2047));
         rd  = 16'($urandom);
         rub = 1'($urandom_range(0, 1));
         rlb = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) do_write(ra, rd, rub, rlb, 1'b1);
         else                           do_read(ra, rub, rlb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
